// File: rtl/m72_bus_pkg.sv
// Shared types and constants for the M72 video-board bus initiator and its
// address decoder.
package m72_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0]  CHARA_HI_DEF   = 4'hD;
    localparam logic [4:0]  CHARA_P_HI_DEF = 5'b11001;
    // Value returned when nothing on the bus answers a read.
    localparam logic [15:0] BUS_IDLE_DATA  = 16'hFFFF;

endpackage

// File: rtl/m72_addr_decode.sv
// Region decode of a word address A[19:1] into the tilemap (CHARA) and
// palette (CHARA_P) selects; IO cycles never select memory regions.
module m72_addr_decode
    import m72_bus_pkg::*;
#(
    parameter logic [3:0] CHARA_HI   = CHARA_HI_DEF,
    parameter logic [4:0] CHARA_P_HI = CHARA_P_HI_DEF
) (
    input  logic [18:0] addr_i,
    input  logic        io_i,
    output logic        chara_o,
    output logic        chara_p_o
);

    logic [13:0] unusedAddrLow;
    assign unusedAddrLow = addr_i[13:0];

    // addr_i[18:15] is A[19:16], addr_i[18:14] is A[19:15].
    assign chara_o   = !io_i && (addr_i[18:15] == CHARA_HI);
    assign chara_p_o = !io_i && (addr_i[18:14] == CHARA_P_HI);

endmodule

// File: rtl/m72_bus_initiator.sv
// Bus master issuing strobed memory/IO cycles toward the M72 video board,
// fronted by a single-outstanding request/response port.
module m72_bus_initiator
    import m72_bus_pkg::*;
#(
    parameter int          STROBE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [3:0]  CHARA_HI       = CHARA_HI_DEF,
    parameter logic [4:0]  CHARA_P_HI     = CHARA_P_HI_DEF
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        MRD,
    output logic        MWR,
    output logic        IORD,
    output logic        IOWR,
    output logic [18:0] A,
    output logic [1:0]  BYTE_SEL,
    output logic [15:0] DIN,
    output logic        CHARA,
    output logic        CHARA_P,
    input  logic [15:0] DOUT,
    input  logic        DOUT_VALID
);

    localparam int             CW           = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  STROBE_LAST  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, io_q;
    logic [18:0]   addr_q;
    logic [1:0]    be_q;
    logic [15:0]   din_q;
    logic          chara_q, charaP_q;
    logic          mrd_q, mwr_q, iord_q, iowr_q;
    logic          captured_q;
    logic [15:0]   capData_q;
    logic          rspValid_q, rspTimeout_q;
    logic [15:0]   rspRdata_q;

    logic          decChara, decCharaP;
    logic          dataSeen, readDone, writeDone;
    logic [15:0]   readResult;
    logic          unusedByteAddr;

    assign unusedByteAddr = req_addr[0];

    m72_addr_decode #(
        .CHARA_HI   (CHARA_HI),
        .CHARA_P_HI (CHARA_P_HI)
    ) u_decode (
        .addr_i    (req_addr[19:1]),
        .io_i      (req_io),
        .chara_o   (decChara),
        .chara_p_o (decCharaP)
    );

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Data arriving in the final strobe cycle still counts as captured.
    assign dataSeen   = captured_q || DOUT_VALID;
    assign readResult = captured_q ? capData_q : (DOUT_VALID ? DOUT : BUS_IDLE_DATA);
    assign writeDone  = we_q && (cnt_q >= STROBE_LAST);
    assign readDone   = !we_q && (((cnt_q >= STROBE_LAST) && dataSeen) || (cnt_q == TIMEOUT_LAST));

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            io_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            din_q        <= '0;
            chara_q      <= 1'b0;
            charaP_q     <= 1'b0;
            mrd_q        <= 1'b0;
            mwr_q        <= 1'b0;
            iord_q       <= 1'b0;
            iowr_q       <= 1'b0;
            captured_q   <= 1'b0;
            capData_q    <= '0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspTimeout_q <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q     <= req_addr[19:1];
                        be_q       <= req_be;
                        din_q      <= req_wdata;
                        we_q       <= req_we;
                        io_q       <= req_io;
                        chara_q    <= decChara;
                        charaP_q   <= decCharaP;
                        captured_q <= 1'b0;
                        cnt_q      <= '0;
                        // No byte lanes enabled: complete without touching the bus.
                        if (req_be == 2'b00) begin
                            state_q      <= HOLD;
                            rspValid_q   <= 1'b1;
                            rspRdata_q   <= BUS_IDLE_DATA;
                            rspTimeout_q <= 1'b0;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= '0;
                    mrd_q   <= !we_q && !io_q;
                    mwr_q   <=  we_q && !io_q;
                    iord_q  <= !we_q &&  io_q;
                    iowr_q  <=  we_q &&  io_q;
                end
                STROBE: begin
                    cnt_q <= cnt_d;
                    if (!we_q && DOUT_VALID && !captured_q) begin
                        captured_q <= 1'b1;
                        capData_q  <= DOUT;
                    end
                    if (writeDone || readDone) begin
                        state_q      <= HOLD;
                        mrd_q        <= 1'b0;
                        mwr_q        <= 1'b0;
                        iord_q       <= 1'b0;
                        iowr_q       <= 1'b0;
                        rspValid_q   <= 1'b1;
                        rspRdata_q   <= we_q ? 16'h0000 : readResult;
                        rspTimeout_q <= !we_q && !dataSeen;
                    end
                end
                HOLD: begin
                    state_q      <= IDLE;
                    chara_q      <= 1'b0;
                    charaP_q     <= 1'b0;
                    rspRdata_q   <= '0;
                    rspTimeout_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rspValid_q;
    assign rsp_rdata   = rspRdata_q;
    assign rsp_timeout = rspTimeout_q;
    assign MRD         = mrd_q;
    assign MWR         = mwr_q;
    assign IORD        = iord_q;
    assign IOWR        = iowr_q;
    assign A           = addr_q;
    assign BYTE_SEL    = be_q;
    assign DIN         = din_q;
    assign CHARA       = chara_q;
    assign CHARA_P     = charaP_q;

endmodule

// File: tb/tb_m72_bus_initiator.sv
// Self-checking bench for m72_bus_initiator: directed scenarios plus random
// transactions compared against a transaction-level expectation model.
module tb_m72_bus_initiator;

    localparam int SC = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, req_we, req_io;
    logic [19:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic        MRD, MWR, IORD, IOWR, CHARA, CHARA_P;
    logic [18:0] A;
    logic [1:0]  BYTE_SEL;
    logic [15:0] DIN, DOUT;
    logic        DOUT_VALID;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    m72_bus_initiator #(.STROBE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_32M    (clk),
        .reset      (reset),
        .req        (req),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_io     (req_io),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .MRD        (MRD),
        .MWR        (MWR),
        .IORD       (IORD),
        .IOWR       (IOWR),
        .A          (A),
        .BYTE_SEL   (BYTE_SEL),
        .DIN        (DIN),
        .CHARA      (CHARA),
        .CHARA_P    (CHARA_P),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction. dvCycle is the 1-based strobe cycle in which the
    // responder presents data (0 or beyond the timeout means never).
    task automatic applyStimulus(input logic we, input logic io, input logic [19:0] addr,
                                 input logic [1:0] be, input logic [15:0] wdata,
                                 input int dvCycle, input logic [15:0] dvData);
        int  waitCycles = 0;
        int  n = 0;
        int  strobeSeen = 0;
        int  wrongStrobe = 0;
        int  readIdx = 0;
        int  respCycle = 0;
        bit  done = 0;
        bit  answered;
        int  expStrobes, expRespCycle;
        logic [15:0] expRdata;
        logic expTimeout, expChara, expCharaP;
        logic [3:0] expStrobeVec, gotStrobeVec;

        answered   = !we && (dvCycle >= 1) && (dvCycle <= TO);
        expChara   = !io && (addr[19:16] == 4'hD);
        expCharaP  = !io && (addr[19:15] == 5'b11001);
        expStrobeVec = {we && io, !we && io, we && !io, !we && !io};
        if (be == 2'b00) begin
            expStrobes = 0; expRdata = 16'hFFFF; expTimeout = 1'b0;
        end else if (we) begin
            expStrobes = SC; expRdata = 16'h0000; expTimeout = 1'b0;
        end else if (answered) begin
            expStrobes = (dvCycle > SC) ? dvCycle : SC; expRdata = dvData; expTimeout = 1'b0;
        end else begin
            expStrobes = TO; expRdata = 16'hFFFF; expTimeout = 1'b1;
        end
        expRespCycle = (be == 2'b00) ? 1 : expStrobes + 2;

        @(negedge clk);
        while (!req_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput("readyBound", 32'd0, 32'd1);
            return;
        end
        req = 1'b1; req_we = we; req_io = io; req_addr = addr; req_be = be; req_wdata = wdata;

        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req = 1'b0;
                req_addr = $urandom; req_wdata = $urandom; req_be = 2'($urandom);
                checkOutput("busyNotReady", {31'd0, req_ready}, 32'd0);
            end
            gotStrobeVec = {IOWR, IORD, MWR, MRD};
            if (gotStrobeVec != 4'b0000) begin
                strobeSeen++;
                if (gotStrobeVec != expStrobeVec || n == 1) wrongStrobe++;
            end
            if (rsp_valid) begin
                done = 1;
                respCycle = n;
                checkOutput("rspCycle", respCycle, expRespCycle);
                checkOutput("strobeCycles", strobeSeen, expStrobes);
                checkOutput("wrongStrobe", wrongStrobe, 0);
                checkOutput("holdStrobesLow", {28'd0, gotStrobeVec}, 32'd0);
                checkOutput("rspRdata", {16'd0, rsp_rdata}, {16'd0, expRdata});
                checkOutput("rspTimeout", {31'd0, rsp_timeout}, {31'd0, expTimeout});
                checkOutput("addr", {13'd0, A}, {13'd0, addr[19:1]});
                checkOutput("byteSel", {30'd0, BYTE_SEL}, {30'd0, be});
                checkOutput("din", {16'd0, DIN}, {16'd0, wdata});
                checkOutput("chara", {31'd0, CHARA}, {31'd0, expChara});
                checkOutput("charaP", {31'd0, CHARA_P}, {31'd0, expCharaP});
                DOUT_VALID = 1'b0;
            end else if (MRD || IORD) begin
                readIdx++;
                DOUT_VALID = (readIdx == dvCycle) || (readIdx > dvCycle && dvCycle != 0 && $urandom_range(0, 1) == 1);
                DOUT = (readIdx == dvCycle) ? dvData : ~dvData;
            end else begin
                DOUT_VALID = ($urandom_range(0, 3) == 0);
                DOUT = $urandom;
            end
        end
        if (!done) begin
            checkOutput("rspBound", 32'd0, 32'd1);
            return;
        end
        @(negedge clk);
        DOUT_VALID = 1'b0;
        checkOutput("pulseOnce", {31'd0, rsp_valid}, 32'd0);
        checkOutput("readyAfter", {31'd0, req_ready}, 32'd1);
        checkOutput("selClear", {30'd0, CHARA, CHARA_P}, 32'd0);
        checkOutput("addrHeld", {13'd0, A}, {13'd0, addr[19:1]});
    endtask

    initial begin
        int guard;
        reset = 1'b1; req = 1'b0; req_we = 1'b0; req_io = 1'b0; req_addr = '0;
        req_be = '0; req_wdata = '0; DOUT = '0; DOUT_VALID = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetReady", {31'd0, req_ready}, 32'd1);
        checkOutput("resetStrobes", {28'd0, IOWR, IORD, MWR, MRD}, 32'd0);
        checkOutput("resetRsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
        checkOutput("resetBus", {A, BYTE_SEL, CHARA, CHARA_P}, 32'd0);
        checkOutput("resetDin", {16'd0, DIN}, 32'd0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 20'hD0010, 2'b11, 16'h1234, 0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 20'hD8002, 2'b11, 16'h0000, 3, 16'hABCD);
        applyStimulus(1'b1, 1'b1, 20'h00082, 2'b01, 16'h00C3, 0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 20'h40000, 2'b11, 16'h0000, 0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 20'hC8004, 2'b11, 16'h0000, 1, 16'h5A5A);
        applyStimulus(1'b0, 1'b0, 20'hC8006, 2'b00, 16'h0000, 1, 16'h1111);
        applyStimulus(1'b0, 1'b1, 20'hC8006, 2'b10, 16'h0000, 16, 16'h2222);

        // Reset in the middle of a write strobe aborts without a response.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_io = 1'b0; req_addr = 20'hD0020; req_be = 2'b11; req_wdata = 16'hBEEF;
        @(negedge clk);
        req = 1'b0;
        guard = 0;
        while (!MWR && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("abortSawStrobe", {31'd0, MWR}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortStrobeLow", {28'd0, IOWR, IORD, MWR, MRD}, 32'd0);
        checkOutput("abortReady", {31'd0, req_ready}, 32'd1);
        guard = 0;
        repeat (5) begin
            if (rsp_valid) guard++;
            @(negedge clk);
        end
        checkOutput("abortNoRsp", guard, 0);
        applyStimulus(1'b1, 1'b0, 20'hD0020, 2'b11, 16'hBEEF, 0, 16'h0000);

        for (int t = 0; t < 40; t++) begin
            logic [19:0] addr;
            case ($urandom_range(0, 3))
                0:       addr = 20'hD0000 | 20'($urandom_range(0, 16'hFFFF));
                1:       addr = 20'hC8000 | 20'($urandom_range(0, 15'h7FFF));
                2:       addr = 20'hC0000 | 20'($urandom_range(0, 16'hFFFF));
                default: addr = 20'($urandom);
            endcase
            applyStimulus(1'($urandom), 1'($urandom), addr, 2'($urandom), 16'($urandom),
                          $urandom_range(0, 20), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/m72_bus_initiator.md
Name: m72_bus_initiator

Overview:
- Bus master that issues CPU-style memory and IO cycles toward the video board (tilemap RAM A/B, scroll ports, palette).
- Drives the responder-side signals: MRD/MWR/IORD/IOWR strobes, A[19:1], BYTE_SEL, DIN, CHARA and CHARA_P.
- Captures read data on DOUT_VALID.
- Fronts a simple request/response port used by the CPU core wrapper and by debug/test-pattern loaders.

Parameters:
- STROBE_CYCLES, 2, minimum strobe width in CLK_32M cycles (>=1).
- TIMEOUT_CYCLES, 16, maximum strobe cycles for a read before it is abandoned (>= STROBE_CYCLES).
- CHARA_HI, 4'hD, A[19:16] value selecting tilemap RAM (CHARA).
- CHARA_P_HI, 5'b11001, A[19:15] value selecting palette RAM (CHARA_P, 0xC8000-0xCFFFF).

Ports:
- CLK_32M  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid.
- req_ready  out  1  high only in IDLE; the request is accepted on req & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_io  in  1  1 = IO space, 0 = memory.
- req_addr  in  20  byte address; bit 0 is ignored.
- req_be  in  2  byte enables [1] = high byte, [0] = low byte.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data, valid with rsp_valid.
- rsp_timeout  out  1  valid with rsp_valid; read ended without DOUT_VALID.
- MRD, MWR, IORD, IOWR  out  1 each  strobes, active-high.
- A  out  19  address [19:1].
- BYTE_SEL  out  2  byte enables.
- DIN  out  16  write data toward the responder.
- CHARA  out  1  tilemap RAM select.
- CHARA_P  out  1  palette select.
- DOUT  in  16  responder read data.
- DOUT_VALID  in  1  responder data valid.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. State is IDLE.
- Reset asserted in any state: strobes deassert at the next edge, state returns to IDLE, and no rsp_valid is issued for the aborted cycle.
- Accept (edge t0): register addr, be, wdata, we, io. Registered outputs A = req_addr[19:1], BYTE_SEL = req_be, DIN = req_wdata.
- Region decode from the registered address, memory cycles only:
  - CHARA = (A[19:16] == CHARA_HI).
  - CHARA_P = (A[19:15] == CHARA_P_HI).
  - Both are forced to 0 when req_io = 1.
- States:
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle): address, selects and DIN stable; all strobes low.
  - STROBE: exactly one strobe high (MWR, MRD, IOWR or IORD, chosen by we/io). A cycle counter starts at 0.
    - Write: exit after STROBE_CYCLES cycles.
    - Read: capture DOUT on the first STROBE cycle with DOUT_VALID = 1; later DOUT_VALID/DOUT is ignored. Exit when count >= STROBE_CYCLES-1 and data has been captured, or when count == TIMEOUT_CYCLES-1.
  - HOLD (1 cycle): strobes low; A, BYTE_SEL, DIN and the selects are held. rsp_valid = 1. rsp_rdata = captured data; for a timed-out read it is 16'hFFFF with rsp_timeout = 1; for a write it is 0.
  - HOLD -> IDLE. Selects clear in IDLE; A, BYTE_SEL and DIN keep their last value.
- Timing with STROBE_CYCLES = 2: SETUP t1, strobe t2-t3, rsp_valid t4, next accept possible at t5. Back-to-back cycles therefore always have at least 2 strobe-low cycles between them.
- DOUT_VALID seen in any state other than STROBE is ignored.
- req_be == 2'b00: accepted, no strobe issued. Goes straight to HOLD the next cycle with rsp_valid = 1, rsp_rdata = 16'hFFFF, rsp_timeout = 0.
- req while not ready is ignored; no queueing.
- Counter width is $clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.

Decomposition:
- Package m72_bus_pkg: state enum (IDLE, SETUP, STROBE, HOLD), region constants CHARA_HI / CHARA_P_HI defaults, bus-idle read value 16'hFFFF.
- Optional sub-module m72_addr_decode: combinational A/io -> CHARA, CHARA_P, shared with the CPU wrapper.
- The FSM and counter stay in this module.

Test Plan:
- Write 0xD0010, data 0x1234, be 2'b11 -> CHARA = 1, A = 0x68008, DIN = 0x1234. MWR high exactly at t2 and t3. rsp_valid at t4 with rsp_rdata = 0.
- Read 0xD8002; responder raises DOUT_VALID with 0xABCD on the 3rd strobe cycle -> MRD high 3 cycles, rsp_rdata = 0xABCD, rsp_timeout = 0.
- IO write to 0x0082 (VSCKB port), be 2'b01 -> IOWR for 2 cycles, CHARA = CHARA_P = 0, BYTE_SEL = 2'b01.
- Read 0x40000 with no responder -> MRD high 16 cycles, rsp_rdata = 0xFFFF, rsp_timeout = 1.
- Palette read at 0xC8004 with DOUT_VALID on strobe cycle 1 -> CHARA_P = 1, CHARA = 0. MRD still 2 cycles, since STROBE_CYCLES is the minimum width.
- Reset asserted during the STROBE of a write -> strobe low on the next edge, req_ready = 1, no rsp_valid. A following request completes normally.
